// File: rtl/endian_pkg.sv
// Network/host byte-order conversion helpers.
// Shared by the NetTLP TX builder and RX parser.
package endian_pkg;

  function automatic logic [15:0] endian_conv16(
    input logic [15:0] v
  );
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [31:0] endian_conv32(
    input logic [31:0] v
  );
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

endpackage

// File: rtl/nettlp_pkg.sv
// NetTLP protocol constants, parser state and header bundle.
// Imported by the RX header parser.
package nettlp_pkg;

  localparam logic [15:0] ETHTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VERIHL  = 8'h45;
  localparam logic [7:0]  IPPROTO_UDP  = 8'd17;
  localparam int          HDR_BEATS    = 6;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } rx_state_t;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] seq;
    logic [31:0] tstamp;
  } nettlp_hdr_t;

endpackage

// File: rtl/axis_reg_slice64.sv
// One-stage 64-bit AXI-Stream register slice.
// Accepts a new beat whenever it is empty or draining.
module axis_reg_slice64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] in_data,
  input  logic [7:0]  in_keep,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_user,
  output logic        in_ready,
  output logic [63:0] out_data,
  output logic [7:0]  out_keep,
  output logic        out_valid,
  output logic        out_last,
  output logic        out_user,
  input  logic        out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_valid <= 1'b1;
      out_last  <= in_last;
      out_user  <= in_user;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nettlp_rx_hdr_parser.sv
// NetTLP RX decoder: strips Eth/IPv4/UDP/NetTLP header, forwards TLP.
// Frame counters are built only with NETTLP_RX_STATS_EN defined.
module nettlp_rx_hdr_parser
  import nettlp_pkg::*;
  import endian_pkg::*;
#(
  parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
  parameter logic [15:0] UDP_PORT_MASK = 16'hFFF0
) (
  input  logic        clk156,
  input  logic        rst_n,
  input  logic [63:0] s_tdata,
  input  logic [7:0]  s_tkeep,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [63:0] m_tdata,
  output logic [7:0]  m_tkeep,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  input  logic        m_tready,
  output logic [31:0] hdr_src_ip,
  output logic [15:0] hdr_src_port,
  output logic [15:0] hdr_dst_port,
  output logic [15:0] hdr_seq,
  output logic [31:0] hdr_tstamp,
  output logic [31:0] stat_rx_cnt,
  output logic [31:0] stat_drop_cnt
);

  rx_state_t   state;
  logic [2:0]  beat;
  logic        run;
  logic [15:0] ethtype;
  logic [7:0]  verihl;
  logic [7:0]  proto;
  nettlp_hdr_t stage;
  nettlp_hdr_t stage_nxt;
  nettlp_hdr_t hdr_q;
  logic        hdr_pend;
  logic        sof;
  logic        slice_ready;
  logic        fire;
  logic        last_hdr;
  logic        hdr_ok;

  assign s_tready = run &&
    (state == ST_PAYLOAD ? slice_ready : 1'b1);
  assign fire     = s_tvalid && s_tready;
  assign last_hdr = beat == 3'(HDR_BEATS - 1);
  assign hdr_ok   = ethtype == ETHTYPE_IPV4 &&
                    verihl == IPV4_VERIHL &&
                    proto == IPPROTO_UDP &&
                    (stage.dport & UDP_PORT_MASK) ==
                    (UDP_PORT_BASE & UDP_PORT_MASK);

  always_comb begin
    stage_nxt        = stage;
    stage_nxt.seq    = endian_conv16(s_tdata[31:16]);
    stage_nxt.tstamp = endian_conv32(s_tdata[63:32]);
  end

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      run      <= 1'b0;
      state    <= ST_HDR;
      beat     <= '0;
      ethtype  <= '0;
      verihl   <= '0;
      proto    <= '0;
      stage    <= '0;
      hdr_q    <= '0;
      hdr_pend <= 1'b0;
      sof      <= 1'b0;
    end else begin
      run <= 1'b1;
      // hdr_* may only move once the previous frame's tail has left
      if (hdr_pend && slice_ready) begin
        hdr_q    <= stage;
        hdr_pend <= 1'b0;
      end
      if (fire) begin
        unique case (state)
          ST_HDR: begin
            case (beat)
              3'd1: begin
                ethtype <= endian_conv16(s_tdata[47:32]);
                verihl  <= s_tdata[55:48];
              end
              3'd2: proto <= s_tdata[63:56];
              3'd3: stage.src_ip <= endian_conv32(s_tdata[47:16]);
              3'd4: begin
                stage.sport <= endian_conv16(s_tdata[31:16]);
                stage.dport <= endian_conv16(s_tdata[47:32]);
              end
              default: ;
            endcase
            if (s_tlast) begin
              beat <= '0;
            end else if (last_hdr) begin
              beat  <= '0;
              stage <= stage_nxt;
              if (hdr_ok) begin
                state <= ST_PAYLOAD;
                sof   <= 1'b1;
                if (slice_ready) hdr_q <= stage_nxt;
                else hdr_pend <= 1'b1;
              end else begin
                state <= ST_DROP;
              end
            end else begin
              beat <= beat + 3'd1;
            end
          end
          ST_PAYLOAD: begin
            sof <= 1'b0;
            if (s_tlast) state <= ST_HDR;
          end
          default: begin
            if (s_tlast) state <= ST_HDR;
          end
        endcase
      end
    end
  end

  axis_reg_slice64 u_slice (
    .clk       (clk156),
    .rst_n     (rst_n),
    .in_data   (s_tdata),
    .in_keep   (s_tkeep),
    .in_valid  (s_tvalid && run && state == ST_PAYLOAD),
    .in_last   (s_tlast),
    .in_user   (sof),
    .in_ready  (slice_ready),
    .out_data  (m_tdata),
    .out_keep  (m_tkeep),
    .out_valid (m_tvalid),
    .out_last  (m_tlast),
    .out_user  (m_tuser),
    .out_ready (m_tready)
  );

  assign hdr_src_ip   = hdr_q.src_ip;
  assign hdr_src_port = hdr_q.sport;
  assign hdr_dst_port = hdr_q.dport;
  assign hdr_seq      = hdr_q.seq;
  assign hdr_tstamp   = hdr_q.tstamp;

`ifdef NETTLP_RX_STATS_EN
  logic [31:0] rx_cnt;
  logic [31:0] drop_cnt;
  logic        rx_inc;
  logic        drop_inc;

  assign rx_inc   = fire && state == ST_PAYLOAD && s_tlast;
  assign drop_inc = fire && state == ST_HDR &&
                    (s_tlast || (last_hdr && !hdr_ok));

  always_ff @(posedge clk156 or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (rx_inc)   rx_cnt   <= rx_cnt + 32'd1;
      if (drop_inc) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign stat_rx_cnt   = rx_cnt;
  assign stat_drop_cnt = drop_cnt;
`else
  assign stat_rx_cnt   = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_nettlp_rx_hdr_parser.sv
// Scoreboard bench for the NetTLP RX header parser.
// Payload beats are queued as driven and popped as they leave m_*.
module tb_nettlp_rx_hdr_parser;

  logic        clk156 = 1'b0;
  logic        rst_n;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tuser;
  logic        m_tready;
  logic [31:0] hdr_src_ip;
  logic [15:0] hdr_src_port;
  logic [15:0] hdr_dst_port;
  logic [15:0] hdr_seq;
  logic [31:0] hdr_tstamp;
  logic [31:0] stat_rx_cnt;
  logic [31:0] stat_drop_cnt;

  nettlp_rx_hdr_parser dut (
    .clk156        (clk156),
    .rst_n         (rst_n),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tvalid      (m_tvalid),
    .m_tlast       (m_tlast),
    .m_tuser       (m_tuser),
    .m_tready      (m_tready),
    .hdr_src_ip    (hdr_src_ip),
    .hdr_src_port  (hdr_src_port),
    .hdr_dst_port  (hdr_dst_port),
    .hdr_seq       (hdr_seq),
    .hdr_tstamp    (hdr_tstamp),
    .stat_rx_cnt   (stat_rx_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  always #3 clk156 = ~clk156;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
    logic [31:0] ip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] seq;
    logic [31:0] ts;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_rx = 0;
  int          exp_drop = 0;
  logic        tog = 1'b0;
  logic        in_pay = 1'b0;
  logic [15:0] last_seq = '0;
  logic [31:0] last_ts = '0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_stats();
`ifdef NETTLP_RX_STATS_EN
    check("stat_rx", 64'(stat_rx_cnt), 64'(exp_rx));
    check("stat_drop", 64'(stat_drop_cnt), 64'(exp_drop));
`else
    check("stat_rx", 64'(stat_rx_cnt), 64'd0);
    check("stat_drop", 64'(stat_drop_cnt), 64'd0);
`endif
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk156);
      #1;
      if (tog) m_tready = ~m_tready;
      else m_tready = 1'b1;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk156);
      if (in_pay && m_tvalid && !m_tready)
        check("s_tready_bp", 64'(s_tready), 64'd0);
      if (rst_n && m_tvalid && m_tready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("m_tdata", m_tdata, e.d);
          check("m_tkeep", 64'(m_tkeep), 64'(e.k));
          check("m_tlast", 64'(m_tlast), 64'(e.l));
          check("m_tuser", 64'(m_tuser), 64'(e.u));
          if (e.u) begin
            check("hdr_src_ip", 64'(hdr_src_ip), 64'(e.ip));
            check("hdr_sport", 64'(hdr_src_port), 64'(e.sport));
            check("hdr_dport", 64'(hdr_dst_port), 64'(e.dport));
            check("hdr_seq", 64'(hdr_seq), 64'(e.seq));
            check("hdr_tstamp", 64'(hdr_tstamp), 64'(e.ts));
          end
        end
      end
    end
  end

  task automatic send_beat(
    input logic [63:0] d,
    input logic [7:0]  k,
    input logic        l
  );
    logic r;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk156);
      r = s_tready;
      @(posedge clk156);
      #1;
      if (r) break;
      if (i == 199) check("ready_timeout", 64'd0, 64'd1);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(
    input logic [15:0] et,
    input logic [7:0]  vi,
    input logic [7:0]  pr,
    input logic [31:0] ip,
    input logic [15:0] sport,
    input logic [15:0] dport,
    input logic [15:0] seq,
    input logic [31:0] ts,
    input int          npay,
    input int          runt_last
  );
    logic [7:0]  hb[48];
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        ok;
    int          total;
    exp_t        e;
    for (int i = 0; i < 48; i++) hb[i] = 8'($urandom);
    {hb[12], hb[13]} = et;
    hb[14] = vi;
    hb[23] = pr;
    {hb[26], hb[27], hb[28], hb[29]} = ip;
    {hb[34], hb[35]} = sport;
    {hb[36], hb[37]} = dport;
    {hb[42], hb[43]} = seq;
    {hb[44], hb[45], hb[46], hb[47]} = ts;
    ok = runt_last < 0 && npay > 0 && et == 16'h0800 &&
         vi == 8'h45 && pr == 8'd17 &&
         (dport & 16'hFFF0) == 16'h3000;
    total = (runt_last >= 0) ? runt_last + 1 : 6 + npay;
    if (ok) begin
      exp_rx++;
      last_seq = seq;
      last_ts  = ts;
    end else begin
      exp_drop++;
    end
    for (int b = 0; b < total; b++) begin
      l = (b == total - 1);
      k = (l && b >= 6) ? 8'h0F : 8'hFF;
      if (b < 6) begin
        for (int j = 0; j < 8; j++) d[8*j +: 8] = hb[8*b + j];
      end else begin
        d = {$urandom, $urandom};
      end
      if (ok && b >= 6) begin
        e.d = d; e.k = k; e.l = l; e.u = (b == 6);
        e.ip = ip; e.sport = sport; e.dport = dport;
        e.seq = seq; e.ts = ts;
        sb.push_back(e);
        in_pay = 1'b1;
      end
      send_beat(d, k, l);
      in_pay = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !m_tvalid) break;
      @(posedge clk156);
    end
    #1;
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic good(
    input logic [15:0] dport,
    input logic [15:0] seq,
    input logic [31:0] ts,
    input int          npay
  );
    send_frame(16'h0800, 8'h45, 8'd17, 32'hC0A80A01,
               16'h1234, dport, seq, ts, npay, -1);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tlast  = 1'b0;
    repeat (3) @(posedge clk156);
    @(negedge clk156);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tdata", m_tdata, 64'd0);
    check("rst_hdr_ip", 64'(hdr_src_ip), 64'd0);
    check("rst_hdr_ts", 64'(hdr_tstamp), 64'd0);
    check_stats();
    @(posedge clk156);
    #1 rst_n = 1'b1;
    @(posedge clk156);
    #1;
    check("run_s_tready", 64'(s_tready), 64'd1);

    good(16'h3000, 16'h002A, 32'h11223344, 3);
    wait_drain();
    check("f1_seq", 64'(hdr_seq), 64'h002A);
    check("f1_ts", 64'(hdr_tstamp), 64'h11223344);
    check_stats();

    send_frame(16'h86DD, 8'h45, 8'd17, 32'h0A000001,
               16'h1, 16'h3000, 16'h0BAD, 32'hBAD0BAD0, 4, -1);
    wait_drain();
    check("ipv6_seq_kept", 64'(hdr_seq), 64'(last_seq));
    check_stats();
    good(16'h3001, 16'h0102, 32'hA5A55A5A, 2);
    wait_drain();

    send_frame(16'h0800, 8'h45, 8'd17, 32'h01020304,
               16'h9, 16'h3000, 16'hDEAD, 32'hDEADBEEF, 0, 3);
    wait_drain();
    check("runt_seq_kept", 64'(hdr_seq), 64'(last_seq));
    check("runt_ts_kept", 64'(hdr_tstamp), 64'(last_ts));
    good(16'h3002, 16'h0777, 32'h01020304, 1);
    wait_drain();
    check_stats();

    send_frame(16'h0800, 8'h45, 8'd17, 32'h01020304,
               16'h9, 16'h3000, 16'hBEEF, 32'h0, 0, -1);
    send_frame(16'h0800, 8'h46, 8'd17, 32'h01020304,
               16'h9, 16'h3000, 16'hBEEF, 32'h0, 2, -1);
    send_frame(16'h0800, 8'h45, 8'd6, 32'h01020304,
               16'h9, 16'h3000, 16'hBEEF, 32'h0, 2, -1);
    good(16'h4000, 16'h0BAD, 32'h0, 2);
    good(16'h300F, 16'h0F0F, 32'hCAFEF00D, 2);
    wait_drain();
    check("dport_seq", 64'(hdr_seq), 64'h0F0F);
    check_stats();

    tog = 1'b1;
    good(16'h3005, 16'h1111, 32'h22223333, 8);
    wait_drain();
    tog = 1'b0;
    check_stats();

    good(16'h3000, 16'h4444, 32'h55556666, 2);
    wait_drain();
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    s_tvalid = 1'b1;
    @(negedge clk156);
    rst_n = 1'b0;
    exp_rx = 0;
    exp_drop = 0;
    last_seq = '0;
    #1;
    check("mid_s_tready", 64'(s_tready), 64'd0);
    check("mid_m_tvalid", 64'(m_tvalid), 64'd0);
    check("mid_hdr_seq", 64'(hdr_seq), 64'd0);
    check("mid_hdr_port", 64'(hdr_dst_port), 64'd0);
    check_stats();
    s_tvalid = 1'b0;
    @(posedge clk156);
    #1 rst_n = 1'b1;
    good(16'h3003, 16'h7777, 32'h88889999, 3);
    wait_drain();
    check("post_rst_seq", 64'(hdr_seq), 64'h7777);
    check_stats();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
